// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of fetched packets between fetch and decode.
// Ports: clk, rst (async, active high), flush; enq_* from fetch,
//   enq_ready/fetch_stall back to fetch; deq_* to decode, count.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             enq_valid,
   input  logic [31:0]      enq_pc,
   input  logic [31:0]      enq_instruction,
   input  logic [31:0]      enq_next_pc,
   output logic             enq_ready,
   output logic             fetch_stall,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [31:0]      deq_pc,
   output logic [31:0]      deq_instruction,
   output logic [31:0]      deq_next_pc,
   output logic [PTR_W:0]   count
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instruction;
      logic [31:0] next_pc;
   } pkt_t;

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   pkt_t             mem [DEPTH];
   pkt_t             head;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             full;
   logic             empty;
   logic             enq_fire;
   logic             deq_fire;

   // Ready/valid come only from registered count, never from inputs.
   assign full        = (count == FULL_CNT);
   assign empty       = (count == '0);
   assign enq_ready   = !full;
   assign fetch_stall = full;
   assign deq_valid   = !empty;

   assign enq_fire = enq_valid && enq_ready;
   assign deq_fire = deq_valid && deq_ready;

   assign head            = mem[rd_ptr];
   assign deq_pc          = deq_valid ? head.pc : '0;
   assign deq_instruction = deq_valid ? head.instruction : '0;
   assign deq_next_pc     = deq_valid ? head.next_pc : '0;

   // Storage holds no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (enq_fire && !flush) begin
         mem[wr_ptr] <= '{pc: enq_pc,
                          instruction: enq_instruction,
                          next_pc: enq_next_pc};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
         if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
         unique case (1'b1)
            (enq_fire && !deq_fire): count <= count + 1'b1;
            (deq_fire && !enq_fire): count <= count - 1'b1;
            default:                 count <= count;
         endcase
      end
   end

endmodule
